ras_stack_p: RTL and testbench

- Parametrised return-address stack for the VLIW front end; next generation of the fixed 14-bit/512-entry RAS.
- Circular buffer with configurable address width and depth; full/empty tracking, overflow wrap, underflow protection, push+pop replace.
- Single-level checkpoint/restore so fetch can roll back speculative calls/returns on branch mispredict.
- Sits beside the fetch PC mux; push on call, pop on return, restore on redirect.

---
 rtl/ras_stack_p.sv | 179 +++++++++++++++++
 tb/tb_ras_stack_p.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_stack_p.sv
// ============================================================================
//  Module      : ras_stack_p
//  Description : Parametrised circular return-address stack with full/empty
//                tracking, overflow wrap, underflow protection, push+pop
//                replace and a single-level checkpoint/restore of the top.
//                Optional macro RAS_ERRCNT_EN adds saturating 16-bit
//                overflow/underflow event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack_p #(
    parameter int AW         = 14,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  push,
    input  logic                  pop,
    input  logic [AW-1:0]         npc,
    input  logic                  ckpt_take,
    input  logic                  ckpt_restore,
    output logic [AW-1:0]         ra,
    output logic                  ra_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [15:0]           ovf_cnt,
    output logic [15:0]           udf_cnt
);

    localparam int                  DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = DEPTH_LOG2'(0) + (DEPTH_LOG2+1)'(DEPTH);

    // Live stack state
    logic [AW-1:0]         stack_q [DEPTH];
    logic [DEPTH_LOG2-1:0] sp_q, sp_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    // Checkpoint state (top entry only)
    logic [DEPTH_LOG2-1:0] ck_sp_q, ck_sp_d;
    logic [DEPTH_LOG2:0]   ck_count_q, ck_count_d;
    logic [AW-1:0]         ck_top_q, ck_top_d;

    // Single storage write port
    logic                  wr_en_d;
    logic [DEPTH_LOG2-1:0] wr_addr_d;
    logic [AW-1:0]         wr_data_d;

    logic                  w_empty;
    logic                  w_full;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_DEPTH_CNT);

    // Next-state decode: restore beats stall, stall beats push/pop/take
    always_comb begin
        sp_d        = sp_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        ck_sp_d     = ck_sp_q;
        ck_count_d  = ck_count_q;
        ck_top_d    = ck_top_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = sp_q;
        wr_data_d   = npc;

        if (ckpt_restore) begin
            sp_d      = ck_sp_q;
            count_d   = ck_count_q;
            wr_en_d   = 1'b1;
            wr_addr_d = ck_sp_q;
            wr_data_d = ck_top_q;
        end else if (!stall) begin
            // Snapshot uses pre-edge state, so same-cycle push/pop are excluded
            if (ckpt_take) begin
                ck_sp_d    = sp_q;
                ck_count_d = count_q;
                ck_top_d   = stack_q[sp_q];
            end

            if (push && pop && !w_empty) begin
                // Tail call: replace the top in place
                wr_en_d   = 1'b1;
                wr_addr_d = sp_q;
                wr_data_d = npc;
            end else if (push) begin
                // Pointer wraps naturally; when full the oldest entry is overwritten
                sp_d      = sp_q + 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = sp_q + 1'b1;
                wr_data_d = npc;
                if (w_full) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (pop) begin
                if (w_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    sp_d    = sp_q - 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // Control and checkpoint registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q        <= '1;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            ck_sp_q     <= '1;
            ck_count_q  <= '0;
            ck_top_q    <= '0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            ck_sp_q     <= ck_sp_d;
            ck_count_q  <= ck_count_d;
            ck_top_q    <= ck_top_d;
        end
    end

    // Entry storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            stack_q[wr_addr_d] <= wr_data_d;
        end
    end

    assign ra        = w_empty ? '0 : stack_q[sp_q];
    assign ra_valid  = ~w_empty;
    assign count     = count_q;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef RAS_ERRCNT_EN
    logic [15:0] ovf_cnt_q;
    logic [15:0] udf_cnt_q;

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            if (overflow_d && (ovf_cnt_q != 16'hFFFF)) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
            if (underflow_d && (udf_cnt_q != 16'hFFFF)) begin
                udf_cnt_q <= udf_cnt_q + 16'd1;
            end
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`else
    assign ovf_cnt = 16'd0;
    assign udf_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ras_stack_p.sv
// ============================================================================
//  Module      : tb_ras_stack_p
//  Description : Scoreboard bench for ras_stack_p with AW=14, DEPTH_LOG2=2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ras_stack_p;

    typedef struct packed {
        logic [13:0] ra;
        logic        vld;
        logic [2:0]  cnt;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        udf;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [13:0] npc = '0;
    logic        ckpt_take = 1'b0;
    logic        ckpt_restore = 1'b0;
    logic [13:0] ra;
    logic        ra_valid;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underflow;
    logic [15:0] ovf_cnt;
    logic [15:0] udf_cnt;

    int    n_tests = 0;
    int    n_fail  = 0;
    snap_t exp_q [$];
    snap_t obs_q [$];
    string tag_q [$];

    ras_stack_p #(.AW(14), .DEPTH_LOG2(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .push(push), .pop(pop), .npc(npc),
        .ckpt_take(ckpt_take), .ckpt_restore(ckpt_restore),
        .ra(ra), .ra_valid(ra_valid), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow),
        .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
    );

    always #5 clk = ~clk;

    // Queue expectation, apply one cycle of stimulus, capture what the DUT shows
    task automatic drive(input logic ph, input logic pp, input logic [13:0] n,
                         input logic tk, input logic rs, input logic st,
                         input logic [13:0] e_ra, input int e_cnt,
                         input logic e_ovf, input logic e_udf, input string tag);
        snap_t e;
        snap_t o;
        e.ra    = e_ra;
        e.vld   = (e_cnt != 0);
        e.cnt   = 3'(e_cnt);
        e.full  = (e_cnt == 4);
        e.empty = (e_cnt == 0);
        e.ovf   = e_ovf;
        e.udf   = e_udf;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        push = ph; pop = pp; npc = n; ckpt_take = tk; ckpt_restore = rs; stall = st;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; ckpt_take = 1'b0; ckpt_restore = 1'b0; stall = 1'b0;
        o = '{ra: ra, vld: ra_valid, cnt: count, full: full, empty: empty,
              ovf: overflow, udf: underflow};
        obs_q.push_back(o);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({ra, ra_valid, count, full, empty, overflow, underflow} !== {14'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got ra=%h vld=%b cnt=%0d full=%b empty=%b ovf=%b udf=%b, expected ra=0 vld=0 cnt=0 full=0 empty=1 ovf=0 udf=0",
                     ra, ra_valid, count, full, empty, overflow, underflow);
        end
        n_tests++;
        if ({ovf_cnt, udf_cnt} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_counters: got ovf=%0d udf=%0d, expected 0 0", ovf_cnt, udf_cnt);
        end
    endtask

    task automatic test_push_pop();
        snap_t e, o; string t;
        drive(1, 0, 14'h100, 0, 0, 0, 14'h100, 1, 0, 0, "pp_push1");
        drive(1, 0, 14'h104, 0, 0, 0, 14'h104, 2, 0, 0, "pp_push2");
        drive(1, 0, 14'h108, 0, 0, 0, 14'h108, 3, 0, 0, "pp_push3");
        drive(0, 1, 14'h0,   0, 0, 0, 14'h104, 2, 0, 0, "pp_pop1");
        drive(0, 1, 14'h0,   0, 0, 0, 14'h100, 1, 0, 0, "pp_pop2");
        drive(0, 1, 14'h0,   0, 0, 0, 14'h0,   0, 0, 0, "pp_pop3");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got ra=%h cnt=%0d snap=%h, expected ra=%h cnt=%0d snap=%h", t, o.ra, o.cnt, o, e.ra, e.cnt, e);
            end
        end
    endtask

    task automatic test_overflow();
        snap_t e, o; string t;
        drive(1, 0, 14'h10, 0, 0, 0, 14'h10, 1, 0, 0, "ov_push10");
        drive(1, 0, 14'h11, 0, 0, 0, 14'h11, 2, 0, 0, "ov_push11");
        drive(1, 0, 14'h12, 0, 0, 0, 14'h12, 3, 0, 0, "ov_push12");
        drive(1, 0, 14'h13, 0, 0, 0, 14'h13, 4, 0, 0, "ov_push13");
        drive(1, 0, 14'h14, 0, 0, 0, 14'h14, 4, 1, 0, "ov_push14");
        drive(0, 0, 14'h0,  0, 0, 1, 14'h14, 4, 0, 0, "ov_stall_clears_pulse");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h13, 3, 0, 0, "ov_pop1");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h12, 2, 0, 0, "ov_pop2");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h11, 1, 0, 0, "ov_pop3");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h0,  0, 0, 0, "ov_pop4_empty");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got ra=%h cnt=%0d snap=%h, expected ra=%h cnt=%0d snap=%h", t, o.ra, o.cnt, o, e.ra, e.cnt, e);
            end
        end
    endtask

    task automatic test_underflow();
        snap_t e, o; string t;
        drive(0, 1, 14'h0,  0, 0, 0, 14'h0,  0, 0, 1, "ud_pop_empty");
        drive(0, 0, 14'h0,  0, 0, 0, 14'h0,  0, 0, 0, "ud_pulse_ends");
        drive(1, 1, 14'h20, 0, 0, 0, 14'h20, 1, 0, 0, "ud_pushpop_empty");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h0,  0, 0, 0, "ud_pop_back");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got ra=%h cnt=%0d snap=%h, expected ra=%h cnt=%0d snap=%h", t, o.ra, o.cnt, o, e.ra, e.cnt, e);
            end
        end
    endtask

    task automatic test_replace();
        snap_t e, o; string t;
        drive(1, 0, 14'h30, 0, 0, 0, 14'h30, 1, 0, 0, "rp_push30");
        drive(1, 0, 14'h34, 0, 0, 0, 14'h34, 2, 0, 0, "rp_push34");
        drive(1, 1, 14'h38, 0, 0, 0, 14'h38, 2, 0, 0, "rp_replace38");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h30, 1, 0, 0, "rp_pop");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h0,  0, 0, 0, "rp_pop_empty");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got ra=%h cnt=%0d snap=%h, expected ra=%h cnt=%0d snap=%h", t, o.ra, o.cnt, o, e.ra, e.cnt, e);
            end
        end
    endtask

    task automatic test_ckpt();
        snap_t e, o; string t;
        drive(1, 0, 14'h40, 0, 0, 0, 14'h40, 1, 0, 0, "ck_push40");
        drive(1, 0, 14'h44, 1, 0, 0, 14'h44, 2, 0, 0, "ck_take_push44");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h40, 1, 0, 0, "ck_pop1");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h0,  0, 0, 0, "ck_pop2");
        drive(0, 0, 14'h0,  0, 1, 0, 14'h40, 1, 0, 0, "ck_restore");
        drive(1, 0, 14'h50, 1, 0, 1, 14'h40, 1, 0, 0, "ck_stall_holds");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h0,  0, 0, 0, "ck_pop3");
        drive(0, 1, 14'h0,  0, 1, 1, 14'h40, 1, 0, 0, "ck_restore_stalled");
        drive(1, 0, 14'h60, 0, 1, 0, 14'h40, 1, 0, 0, "ck_restore_beats_push");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h0,  0, 0, 0, "ck_pop_final");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got ra=%h cnt=%0d snap=%h, expected ra=%h cnt=%0d snap=%h", t, o.ra, o.cnt, o, e.ra, e.cnt, e);
            end
        end
    endtask

    task automatic test_errcnt();
        snap_t e, o; string t;
        logic [15:0] exp_ovf, exp_udf;
`ifdef RAS_ERRCNT_EN
        exp_ovf = 16'd3;
        exp_udf = 16'd2;
`else
        exp_ovf = 16'd0;
        exp_udf = 16'd0;
`endif
        do_reset();
        drive(1, 0, 14'h70, 0, 0, 0, 14'h70, 1, 0, 0, "ec_push70");
        drive(1, 0, 14'h71, 0, 0, 0, 14'h71, 2, 0, 0, "ec_push71");
        drive(1, 0, 14'h72, 0, 0, 0, 14'h72, 3, 0, 0, "ec_push72");
        drive(1, 0, 14'h73, 0, 0, 0, 14'h73, 4, 0, 0, "ec_push73");
        drive(1, 0, 14'h74, 0, 0, 0, 14'h74, 4, 1, 0, "ec_ovf1");
        drive(1, 0, 14'h75, 0, 0, 0, 14'h75, 4, 1, 0, "ec_ovf2");
        drive(1, 0, 14'h76, 0, 0, 0, 14'h76, 4, 1, 0, "ec_ovf3");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h75, 3, 0, 0, "ec_pop1");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h74, 2, 0, 0, "ec_pop2");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h73, 1, 0, 0, "ec_pop3");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h0,  0, 0, 0, "ec_pop4");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h0,  0, 0, 1, "ec_udf1");
        drive(0, 1, 14'h0,  0, 0, 0, 14'h0,  0, 0, 1, "ec_udf2");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got ra=%h cnt=%0d snap=%h, expected ra=%h cnt=%0d snap=%h", t, o.ra, o.cnt, o, e.ra, e.cnt, e);
            end
        end
        n_tests++;
        if (ovf_cnt !== exp_ovf) begin
            n_fail++;
            $display("FAIL ovf_cnt: got %0d, expected %0d", ovf_cnt, exp_ovf);
        end
        n_tests++;
        if (udf_cnt !== exp_udf) begin
            n_fail++;
            $display("FAIL udf_cnt: got %0d, expected %0d", udf_cnt, exp_udf);
        end
        // Leave a live entry, then hit reset between clock edges
        push = 1'b1; npc = 14'h7A;
        @(posedge clk);
        #1;
        push = 1'b0;
        n_tests++;
        if ({ra, count} !== {14'h7A, 3'd1}) begin
            n_fail++;
            $display("FAIL pre_async_rst: got ra=%h cnt=%0d, expected ra=7a cnt=1", ra, count);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({empty, ra_valid, ra, count, ovf_cnt, udf_cnt} !== {1'b1, 1'b0, 14'h0, 3'd0, 16'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL async_rst: got empty=%b vld=%b ra=%h cnt=%0d ovf=%0d udf=%0d, expected empty=1 vld=0 ra=0 cnt=0 ovf=0 udf=0",
                     empty, ra_valid, ra, count, ovf_cnt, udf_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_ckpt();
        test_errcnt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
